// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM.
// States, opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    logic [2:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_LUI:  sel = IMM_U;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decode from ALUOp and the instruction
// function fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            // funct7b5 only means sub for R-type
            if (op5 && funct7b5)
              alu_control = ALU_SUB;
            else
              alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM for the shared datapath.
// ILLEGAL_OP_TRAP_EN: illegal opcodes trap instead of NOP.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       IllegalOp
);

  localparam logic [3:0] IDLE_LAST =
    4'(RESET_IDLE_CYCLES - 1);

  state_t     state;
  state_t     next;
  logic [3:0] idle_cnt;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idle_cnt <= 4'd0;
    end else begin
      state <= next;
      if (state == S_IDLE)
        idle_cnt <= idle_cnt + 4'd1;
    end
  end

  always_comb begin
    next      = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (idle_cnt == IDLE_LAST)
          next = S_FETCH;
      end
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (MemReady) begin
          IRWrite   = 1'b1;
          pc_update = 1'b1;
          next      = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:         next = S_EXECR;
          OP_I:         next = S_EXECI;
          OP_BEQ:       next = S_BEQ;
          OP_JAL:       next = S_JAL;
          OP_LUI:       next = S_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      next = S_TRAP;
`else
          default:      next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady)
          next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady)
          next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        next    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        next      = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        next    = S_ALUWB;
      end
      S_TRAP: begin
        next = S_TRAP;
      end
      default: next = S_IDLE;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign ImmSrc  = (state == S_IDLE) ? IMM_I
                                     : imm_sel(op);

`ifdef ILLEGAL_OP_TRAP_EN
  assign IllegalOp = (state == S_TRAP);
`else
  assign IllegalOp = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule
